// File: rtl/csi_tx_packet_generator.sv
// CSI-2 transmit packet builder: frames FS/FE short packets and video lines
// (header + ECC, payload, CRC-16 footer), then holds HS low for an LP gap.
module csi_tx_packet_generator #(
    parameter logic [1:0]  VC         = 2'b00,
    parameter logic [5:0]  FS_DT      = 6'h00,
    parameter logic [5:0]  FE_DT      = 6'h01,
    parameter logic [5:0]  VIDEO_DT   = 6'h2A,
    parameter logic [15:0] MAX_LEN    = 16'd8192,
    parameter logic [15:0] FRAME_MAX  = 16'd65535,
    parameter logic [7:0]  GAP_CYCLES = 8'd16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [15:0] cmd_len,
    input  logic [31:0] pay_data,
    input  logic        pay_valid,
    output logic        pay_ready,
    output logic [31:0] tx_data,
    output logic [3:0]  tx_keep,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_frame,
    output logic        tx_hs,
    output logic [15:0] frame_num
);
    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, FOOTER, GAP} state_t;

    localparam logic [1:0] T_FS   = 2'd0;
    localparam logic [1:0] T_FE   = 2'd1;
    localparam logic [1:0] T_LINE = 2'd2;

    function automatic logic [5:0] ecc_of(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    // Reflected CRC-16 (0x8408); word bit i is the i-th bit on the wire.
    function automatic logic [15:0] crc_word(input logic [15:0] c_in, input logic [31:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 0; i < 32; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'h8408;
            else             c = c >> 1;
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  type_q, type_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  gap_q, gap_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] frame_num_q, frame_num_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic [3:0]  tx_keep_q, tx_keep_d;
    logic        tx_valid_q, tx_valid_d;
    logic        tx_frame_q, tx_frame_d;
    logic        tx_hs_q, tx_hs_d;
    logic        cmd_ready_q, cmd_ready_d;

    logic        load;
    logic [15:0] fn_next;
    logic [15:0] len_masked;
    logic [15:0] cnt_next;
    logic [15:0] hdr_wc;
    logic [5:0]  hdr_dt;
    logic [23:0] hdr_bits;

    assign load       = !tx_valid_q || tx_ready;
    assign pay_ready  = (state_q == PAYLOAD) && load && enable;
    assign cmd_ready  = cmd_ready_q && enable;
    assign fn_next    = (frame_num_q == 16'd0 || frame_num_q == FRAME_MAX) ? 16'd1 : frame_num_q + 16'd1;
    assign len_masked = cmd_len & 16'hFFFC;
    assign cnt_next   = cnt_q + 16'd4;
    assign hdr_bits   = {hdr_wc, VC, hdr_dt};

    assign tx_data   = tx_data_q;
    assign tx_keep   = tx_keep_q;
    assign tx_valid  = tx_valid_q;
    assign tx_frame  = tx_frame_q;
    assign tx_hs     = tx_hs_q;
    assign frame_num = frame_num_q;

    always_comb begin
        hdr_wc = len_q;
        hdr_dt = VIDEO_DT;
        case (type_q)
            T_FS:    begin hdr_wc = fn_next;     hdr_dt = FS_DT; end
            T_FE:    begin hdr_wc = frame_num_q; hdr_dt = FE_DT; end
            default: begin hdr_wc = len_q;       hdr_dt = VIDEO_DT; end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        crc_d       = crc_q;
        frame_num_d = frame_num_q;
        tx_data_d   = tx_data_q;
        tx_keep_d   = tx_keep_q;
        tx_valid_d  = tx_valid_q;
        tx_frame_d  = tx_frame_q;
        tx_hs_d     = tx_hs_q;

        if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready && cmd_type != 2'd3) begin
                    type_d  = cmd_type;
                    len_d   = (len_masked > MAX_LEN) ? MAX_LEN : len_masked;
                    tx_hs_d = 1'b1;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (load) begin
                    tx_data_d  = {2'b00, ecc_of(hdr_bits), hdr_bits};
                    tx_keep_d  = 4'hF;
                    tx_valid_d = 1'b1;
                    tx_frame_d = 1'b1;
                    crc_d      = 16'hFFFF;
                    cnt_d      = 16'd0;
                    if (type_q == T_FS) frame_num_d = fn_next;
                    if (type_q != T_LINE)   state_d = GAP;
                    else if (len_q == 16'd0) state_d = FOOTER;
                    else                     state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (pay_valid && pay_ready) begin
                    tx_data_d  = pay_data;
                    tx_keep_d  = 4'hF;
                    tx_valid_d = 1'b1;
                    crc_d      = crc_word(crc_q, pay_data);
                    cnt_d      = cnt_next;
                    if (cnt_next >= len_q) state_d = FOOTER;
                end
            end
            FOOTER: begin
                if (load) begin
                    tx_data_d  = {16'h0000, crc_q};
                    tx_keep_d  = 4'b0011;
                    tx_valid_d = 1'b1;
                    state_d    = GAP;
                end
            end
            GAP: begin
                // Counting starts once the final word has left the output register.
                if (load) begin
                    tx_frame_d = 1'b0;
                    tx_hs_d    = 1'b0;
                    if (gap_q + 8'd1 >= GAP_CYCLES) begin
                        gap_d   = 8'd0;
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            type_q      <= 2'd0;
            len_q       <= 16'd0;
            cnt_q       <= 16'd0;
            gap_q       <= 8'd0;
            crc_q       <= 16'hFFFF;
            frame_num_q <= 16'd0;
            tx_data_q   <= 32'd0;
            tx_keep_q   <= 4'd0;
            tx_valid_q  <= 1'b0;
            tx_frame_q  <= 1'b0;
            tx_hs_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else if (enable) begin
            state_q     <= state_d;
            type_q      <= type_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            crc_q       <= crc_d;
            frame_num_q <= frame_num_d;
            tx_data_q   <= tx_data_d;
            tx_keep_q   <= tx_keep_d;
            tx_valid_q  <= tx_valid_d;
            tx_frame_q  <= tx_frame_d;
            tx_hs_q     <= tx_hs_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end
endmodule

// File: tb/tb_csi_tx_packet_generator.sv
// Randomized bench for csi_tx_packet_generator: expected word stream is built
// per command from packet rules (ECC column table, byte-table CRC) and scoreboarded.
module tb_csi_tx_packet_generator;
    localparam logic [15:0] FMAX = 16'd3;
    localparam int          GAP  = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_type = 2'd0;
    logic [15:0] cmd_len = 16'd0;
    logic [31:0] pay_data = 32'd0;
    logic        pay_valid = 1'b0;
    logic        pay_ready;
    logic [31:0] tx_data;
    logic [3:0]  tx_keep;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        tx_frame;
    logic        tx_hs;
    logic [15:0] frame_num;

    csi_tx_packet_generator #(.FRAME_MAX(FMAX)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_len(cmd_len),
        .pay_data(pay_data), .pay_valid(pay_valid), .pay_ready(pay_ready),
        .tx_data(tx_data), .tx_keep(tx_keep), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_frame(tx_frame), .tx_hs(tx_hs), .frame_num(frame_num)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [35:0] exp_q[$];
    logic [31:0] pay_q[$];
    int          rdy_mode = 0;
    int          payv_mode = 0;
    int          en_mode = 0;
    int          pay_fired = 0;
    logic [15:0] fn_model = 16'd0;
    logic [15:0] crc_tbl[256];
    logic [31:0] vec[6];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic logic [5:0] ecc_col(input int i);
        case (i)
            0: return 6'h07;  1: return 6'h0B;  2: return 6'h0D;  3: return 6'h0E;
            4: return 6'h13;  5: return 6'h15;  6: return 6'h16;  7: return 6'h19;
            8: return 6'h1A;  9: return 6'h1C; 10: return 6'h23; 11: return 6'h25;
           12: return 6'h26; 13: return 6'h29; 14: return 6'h2A; 15: return 6'h2C;
           16: return 6'h31; 17: return 6'h32; 18: return 6'h34; 19: return 6'h38;
           20: return 6'h1F; 21: return 6'h2F; 22: return 6'h37; default: return 6'h3B;
        endcase
    endfunction

    function automatic logic [35:0] hdr(input logic [5:0] dt, input logic [15:0] wc);
        logic [23:0] d;
        logic [5:0]  e;
        d = {wc, 2'b00, dt};
        e = 6'd0;
        for (int i = 0; i < 24; i++) if (d[i]) e = e ^ ecc_col(i);
        return {4'hF, 2'b00, e, d};
    endfunction

    // Stimulus drivers for downstream ready and clock enable.
    initial forever begin
        @(posedge clock); #1;
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = ($urandom_range(0, 2) != 0);
        endcase
        enable = (en_mode == 0) ? 1'b1 : ($urandom_range(0, 9) != 0);
    end

    // Payload source.
    initial begin
        logic fire;
        forever begin
            @(negedge clock);
            fire = pay_valid && pay_ready && !reset;
            @(posedge clock); #1;
            if (reset) begin
                pay_q.delete();
                pay_valid = 1'b0;
            end else begin
                if (fire) begin
                    void'(pay_q.pop_front());
                    pay_fired++;
                end
                if (pay_q.size() > 0 && (payv_mode == 0 || $urandom_range(0, 2) != 0)) begin
                    pay_valid = 1'b1;
                    pay_data  = pay_q[0];
                end else begin
                    pay_valid = 1'b0;
                    pay_data  = $urandom;
                end
            end
        end
    end

    // Compare process: scoreboard on every transfer plus per-cycle invariants.
    initial begin
        logic [35:0] w;
        int low_cnt = 0;
        bit hs_prev = 1'b0;
        bit hs_first = 1'b1;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete();
                hs_first = 1'b1;
                hs_prev  = 1'b0;
                low_cnt  = 0;
                continue;
            end
            if (tx_valid) chk("valid_frame_hs", {62'd0, tx_frame, tx_hs}, 64'd3);
            if (cmd_ready) chk("ready_idle_quiet", {62'd0, tx_hs, tx_valid}, 64'd0);
            if (tx_hs) begin
                if (!hs_prev && !hs_first) chk("lp_gap_ge_min", {63'd0, low_cnt >= GAP}, 64'd1);
                hs_first = 1'b0;
                low_cnt  = 0;
            end else begin
                low_cnt++;
            end
            hs_prev = tx_hs;
            if (tx_valid && tx_ready && enable) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word got=%0h want=none", {tx_keep, tx_data});
                end else begin
                    w = exp_q.pop_front();
                    chk("tx_word", {28'd0, tx_keep, tx_data}, {28'd0, w});
                end
            end
        end
    end

    task automatic issue_cmd(input logic [1:0] t, input logic [15:0] clen, input bit use_vec,
                             output logic [15:0] wc, output logic [15:0] crc);
        logic [15:0] len;
        logic [31:0] w[$];
        logic [35:0] e[$];
        int k;
        len = clen & 16'hFFFC;
        if (len > 16'd8192) len = 16'd8192;
        crc = 16'hFFFF;
        wc  = 16'd0;
        if (t == 2'd2) begin
            for (int i = 0; i < len / 4; i++) w.push_back(use_vec ? vec[i] : $urandom);
            foreach (w[i]) for (int b = 0; b < 4; b++)
                crc = (crc >> 8) ^ crc_tbl[crc[7:0] ^ w[i][8*b +: 8]];
        end
        case (t)
            2'd0: begin
                fn_model = (fn_model == 16'd0 || fn_model == FMAX) ? 16'd1 : fn_model + 16'd1;
                wc = fn_model;
                e.push_back(hdr(6'h00, wc));
            end
            2'd1: begin
                wc = fn_model;
                e.push_back(hdr(6'h01, wc));
            end
            2'd2: begin
                wc = len;
                e.push_back(hdr(6'h2A, wc));
                foreach (w[i]) e.push_back({4'hF, w[i]});
                e.push_back({4'b0011, 16'h0000, crc});
            end
            default: ;
        endcase
        foreach (w[i]) pay_q.push_back(w[i]);
        @(posedge clock); #1;
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_len   = clen;
        for (k = 0; k < 2000; k++) begin
            @(negedge clock);
            if (cmd_ready) break;
        end
        if (k == 2000) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout got=0 want=1");
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        cmd_len   = 16'($urandom);
        foreach (e[i]) exp_q.push_back(e[i]);
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 40000; k++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && pay_q.size() == 0) break;
        end
        if (k == 40000) begin
            checks++;
            errors++;
            $display("FAIL packet_timeout got=%0d want=0", exp_q.size());
        end
        chk("frame_num", {48'd0, frame_num}, {48'd0, fn_model});
    endtask

    task automatic send(input logic [1:0] t, input logic [15:0] clen, input bit use_vec,
                        output logic [15:0] wc, output logic [15:0] crc);
        issue_cmd(t, clen, use_vec, wc, crc);
        wait_done();
    endtask

    task automatic do_reset();
        @(posedge clock); #2;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_outputs", {cmd_ready, pay_ready, tx_data, tx_keep, tx_valid, tx_frame, tx_hs, frame_num},
            {1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'd0});
        @(posedge clock); #2;
        reset = 1'b0;
        fn_model = 16'd0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] wc, crc, fs_wc;
        logic [15:0] fs_exp[4];
        int base;
        fs_exp[0] = 16'd1; fs_exp[1] = 16'd2; fs_exp[2] = 16'd3; fs_exp[3] = 16'd1;
        vec[0] = 32'h020000FF; vec[1] = 32'h72F3DCB9; vec[2] = 32'h5AB8D4BB;
        vec[3] = 32'h7CC275C8; vec[4] = 32'hDF05F881; vec[5] = 32'h010000FF;
        for (int b = 0; b < 256; b++) begin
            logic [15:0] c;
            c = 16'(b);
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
            crc_tbl[b] = c;
        end

        do_reset();
        chk("model_fs1_header", {28'd0, hdr(6'h00, 16'd1)}, 64'hF1A000100);

        // Frame start, then HS must stay low through the gap.
        send(2'd0, 16'd0, 1'b0, wc, crc);
        chk("fs1_wc", {48'd0, wc}, 64'd1);
        for (int i = 0; i < GAP; i++) begin
            @(negedge clock);
            chk("fs1_hs_gap", {63'd0, tx_hs}, 64'd0);
        end

        send(2'd2, 16'd24, 1'b1, wc, crc);
        chk("vec_wc", {48'd0, wc}, 64'd24);
        chk("vec_crc", {48'd0, crc}, 64'h00F0);

        rdy_mode = 1; payv_mode = 1;
        send(2'd2, 16'd24, 1'b1, wc, crc);
        chk("vec_bp_crc", {48'd0, crc}, 64'h00F0);
        rdy_mode = 0; payv_mode = 0;

        send(2'd2, 16'd9, 1'b0, wc, crc);
        chk("len9_wc", {48'd0, wc}, 64'd8);
        send(2'd2, 16'd0, 1'b0, wc, crc);
        chk("len0_crc", {48'd0, crc}, 64'hFFFF);
        send(2'd3, 16'd12, 1'b0, wc, crc);

        // Frame counter wrap with FRAME_MAX=3.
        do_reset();
        rdy_mode = 2;
        for (int i = 0; i < 4; i++) begin
            send(2'd0, 16'd0, 1'b0, fs_wc, crc);
            chk("fs_wc_seq", {48'd0, fs_wc}, {48'd0, fs_exp[i]});
            chk("frame_num_out", {48'd0, frame_num}, {48'd0, fs_exp[i]});
            send(2'd1, 16'd0, 1'b0, wc, crc);
            chk("fe_wc_matches_fs", {48'd0, wc}, {48'd0, fs_wc});
        end

        // Randomized command mix with backpressure, payload gaps and enable freezes.
        for (int n = 0; n < 30; n++) begin
            logic [1:0] t;
            rdy_mode  = $urandom_range(0, 2);
            payv_mode = $urandom_range(0, 1);
            en_mode   = $urandom_range(0, 1);
            t = ($urandom_range(0, 9) < 6) ? 2'd2 : 2'($urandom_range(0, 3));
            send(t, 16'($urandom_range(0, 64)), 1'b0, wc, crc);
        end
        en_mode = 0;
        send(2'd2, 16'hFFFF, 1'b0, wc, crc);
        chk("clamp_wc", {48'd0, wc}, 64'd8192);

        // Reset in the middle of a line's payload.
        rdy_mode = 0; payv_mode = 0;
        base = pay_fired;
        issue_cmd(2'd2, 16'd40, 1'b0, wc, crc);
        for (int k = 0; k < 200 && pay_fired < base + 2; k++) @(negedge clock);
        chk("midpkt_two_words", {32'd0, 32'(pay_fired - base)}, 64'd2);
        @(posedge clock); #2;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("midpkt_rst_quiet", {61'd0, tx_valid, tx_hs, cmd_ready}, 64'd0);
        @(posedge clock); #2;
        reset = 1'b0;
        fn_model = 16'd0;
        send(2'd0, 16'd0, 1'b0, wc, crc);
        chk("post_rst_fs_wc", {48'd0, wc}, 64'd1);

        repeat (4) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
